// File: rtl/pixel_pattern_gen.sv
// pixel_pattern_gen
//
// Test-pattern pixel source feeding top_vgatest. Each fetch_next_pixel
// strobe advances the raster position (x, y) and the outputs present the
// RGB888 value of the new position one edge later (registered outputs,
// loaded every cycle from the *next* state, so the pixel that matches the
// position is visible on the same edge that moves the position).
//
// Patterns (mode): 0 solid, 1 colour bars, 2 R/G/B cycle, 3 checkerboard.
// The pattern select is only taken at end of frame or on frame_start.
//
// Optional feature: define PATTERN_SCROLL_EN to add a horizontal scroll
// offset that steps by one pixel every frame (modes 1 and 3 only).
//
// Ports:
//   clk_pixel         pixel clock, rising edge
//   reset             asynchronous, active-high reset
//   fetch_next_pixel  consumer took the current pixel, advance
//   frame_start       resynchronise to pixel (0,0), load mode
//   mode[1:0]         pattern select
//   solid_rgb[23:0]   {R,G,B} for solid mode and checkerboard "on" cells
//   r_o/g_o/b_o[7:0]  current pixel colour
//   x_o/y_o[10:0]     current pixel position
//   frame_cnt[7:0]    completed-frame counter (wraps)
module pixel_pattern_gen #(
    parameter int X         = 800,
    parameter int Y         = 600,
    parameter int CELL_LOG2 = 5,
    parameter int BAR_W     = X / 8
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        fetch_next_pixel,
    input  logic        frame_start,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic [7:0]  frame_cnt
);

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_RGB   = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    localparam logic [1:0] RGB_R = 2'd0;
    localparam logic [1:0] RGB_G = 2'd1;
    localparam logic [1:0] RGB_B = 2'd2;

    localparam logic [10:0] X_LAST   = 11'(X - 1);
    localparam logic [10:0] Y_LAST   = 11'(Y - 1);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    // Bar position is tracked as (index, pixels into bar) so no divider is
    // needed. The index saturates at 7, letting the last bar absorb the
    // remainder when X is not a multiple of 8.
    function automatic logic [13:0] bar_adv(input logic [2:0] idx, input logic [10:0] cnt);
        logic [2:0]  ni;
        logic [10:0] nc;
        ni = idx;
        nc = cnt + 11'd1;
        if (cnt == BAR_LAST) begin
            nc = 11'd0;
            if (idx != 3'd7) ni = idx + 3'd1;
        end
        return {ni, nc};
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // State registers (x_o, y_o, frame_cnt are the registers themselves)
    logic [1:0]  mode_q;
    logic [2:0]  bar_idx_q;
    logic [10:0] bar_cnt_q;
    logic [1:0]  rgb_q;

    // Next-state values
    logic [10:0] x_n, y_n, sx_n;
    logic [7:0]  fc_n;
    logic [1:0]  mode_n;
    logic [2:0]  bar_idx_n, pre_idx;
    logic [10:0] bar_cnt_n, pre_cnt;
    logic [1:0]  rgb_n;
    logic        eof;
    logic        wrap_n;
    logic [23:0] pix;

`ifdef PATTERN_SCROLL_EN
    // Scroll offset plus the bar position of that offset, kept in step so
    // the bar counters can be preloaded at the start of each line.
    logic [10:0] off_q, off_n;
    logic [2:0]  off_idx_q, off_idx_n;
    logic [10:0] off_cnt_q, off_cnt_n;
    logic [11:0] sx_sum;
`endif

    always_comb begin
        x_n       = x_o;
        y_n       = y_o;
        fc_n      = frame_cnt;
        mode_n    = mode_q;
        bar_idx_n = bar_idx_q;
        bar_cnt_n = bar_cnt_q;
        rgb_n     = rgb_q;
        eof       = 1'b0;
        wrap_n    = 1'b0;

        // Raster advance; frame_start takes priority and drops a fetch
        if (frame_start) begin
            x_n    = 11'd0;
            y_n    = 11'd0;
            mode_n = mode;
        end else if (fetch_next_pixel) begin
            if (x_o == X_LAST) begin
                x_n = 11'd0;
                if (y_o == Y_LAST) begin
                    y_n    = 11'd0;
                    fc_n   = frame_cnt + 8'd1;
                    mode_n = mode;
                    eof    = 1'b1;
                end else begin
                    y_n = y_o + 11'd1;
                end
            end else begin
                x_n = x_o + 11'd1;
            end
        end

`ifdef PATTERN_SCROLL_EN
        off_n     = off_q;
        off_idx_n = off_idx_q;
        off_cnt_n = off_cnt_q;
        if (eof) begin
            if (off_q == X_LAST) begin
                off_n     = 11'd0;
                off_idx_n = 3'd0;
                off_cnt_n = 11'd0;
            end else begin
                off_n                  = off_q + 11'd1;
                {off_idx_n, off_cnt_n} = bar_adv(off_idx_q, off_cnt_q);
            end
        end
        // Scrolled column, (x + offset) mod X; both terms are < X
        sx_sum = {1'b0, x_n} + {1'b0, off_n};
        if (sx_sum >= 12'(X)) sx_sum = sx_sum - 12'(X);
        sx_n    = sx_sum[10:0];
        pre_idx = off_idx_n;
        pre_cnt = off_cnt_n;
        // Scrolled column wrapped past X-1 mid-line: bars restart at 0
        wrap_n  = (sx_n == 11'd0);
`else
        sx_n    = x_n;
        pre_idx = 3'd0;
        pre_cnt = 11'd0;
`endif

        // Per-pixel pattern state only moves when the position moves
        if (frame_start || fetch_next_pixel) begin
            if (x_n == 11'd0) begin
                bar_idx_n = pre_idx;
                bar_cnt_n = pre_cnt;
                rgb_n     = RGB_R;
            end else begin
                case (rgb_q)
                    RGB_R:   rgb_n = RGB_G;
                    RGB_G:   rgb_n = RGB_B;
                    default: rgb_n = RGB_R;
                endcase
                if (wrap_n) begin
                    bar_idx_n = 3'd0;
                    bar_cnt_n = 11'd0;
                end else begin
                    {bar_idx_n, bar_cnt_n} = bar_adv(bar_idx_q, bar_cnt_q);
                end
            end
        end
    end

    // Colour of the pixel the next state points at
    always_comb begin
        pix = 24'h000000;
        case (mode_n)
            MODE_SOLID: pix = solid_rgb;
            MODE_BARS:  pix = bar_color(bar_idx_n);
            MODE_RGB: begin
                case (rgb_n)
                    RGB_R:   pix = 24'hFF0000;
                    RGB_G:   pix = 24'h00FF00;
                    default: pix = 24'h0000FF;
                endcase
            end
            MODE_CHECK: pix = (sx_n[CELL_LOG2] ^ y_n[CELL_LOG2]) ? 24'h000000 : solid_rgb;
            default:    pix = 24'h000000;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            x_o       <= 11'd0;
            y_o       <= 11'd0;
            frame_cnt <= 8'd0;
            mode_q    <= MODE_SOLID;
            bar_idx_q <= 3'd0;
            bar_cnt_q <= 11'd0;
            rgb_q     <= RGB_R;
            r_o       <= 8'd0;
            g_o       <= 8'd0;
            b_o       <= 8'd0;
        end else begin
            x_o       <= x_n;
            y_o       <= y_n;
            frame_cnt <= fc_n;
            mode_q    <= mode_n;
            bar_idx_q <= bar_idx_n;
            bar_cnt_q <= bar_cnt_n;
            rgb_q     <= rgb_n;
            r_o       <= pix[23:16];
            g_o       <= pix[15:8];
            b_o       <= pix[7:0];
        end
    end

`ifdef PATTERN_SCROLL_EN
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            off_q     <= 11'd0;
            off_idx_q <= 3'd0;
            off_cnt_q <= 11'd0;
        end else begin
            off_q     <= off_n;
            off_idx_q <= off_idx_n;
            off_cnt_q <= off_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Bench for pixel_pattern_gen. A full-size instance (800x600) covers the
// pattern values; a small instance (16x4, 2-pixel cells, 2-pixel bars)
// covers frame wrap, frame counter wrap and scroll in few cycles.
module tb_pixel_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch, fs, fetch_s, fs_s;
    logic [1:0]  mode;
    logic [23:0] solid;

    logic [7:0]  r, g, b, r_s, g_s, b_s;
    logic [10:0] x, y, x_s, y_s;
    logic [7:0]  fc, fc_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pixel_pattern_gen dut (
        .clk_pixel(clk), .reset(reset), .fetch_next_pixel(fetch), .frame_start(fs),
        .mode(mode), .solid_rgb(solid), .r_o(r), .g_o(g), .b_o(b),
        .x_o(x), .y_o(y), .frame_cnt(fc)
    );

    pixel_pattern_gen #(.X(16), .Y(4), .CELL_LOG2(1)) dut_s (
        .clk_pixel(clk), .reset(reset), .fetch_next_pixel(fetch_s), .frame_start(fs_s),
        .mode(mode), .solid_rgb(solid), .r_o(r_s), .g_o(g_s), .b_o(b_s),
        .x_o(x_s), .y_o(y_s), .frame_cnt(fc_s)
    );

    wire [23:0] rgb   = {r, g, b};
    wire [23:0] rgb_s = {r_s, g_s, b_s};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        fs = 1'b1; tick(); fs = 1'b0;
    endtask

    task automatic fetch_n(input int n);
        fetch = 1'b1; repeat (n) tick(); fetch = 1'b0;
    endtask

    task automatic fetch_s_n(input int n);
        fetch_s = 1'b1; repeat (n) tick(); fetch_s = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch = 0; fs = 0; fetch_s = 0; fs_s = 0;
        mode = 2'd0; solid = 24'h123456;
        tick(); tick();
        n_cmp++;
        if ({rgb, x, y, fc} !== 54'd0) begin
            n_err++; $display("FAIL reset_state: got rgb=%h x=%0d y=%0d fc=%0d want all 0", rgb, x, y, fc);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (rgb !== 24'h123456 || x !== 11'd0 || y !== 11'd0) begin
            n_err++; $display("FAIL first_pixel: got rgb=%h x=%0d y=%0d want 123456 0 0", rgb, x, y);
        end
    endtask

    task automatic test_bars();
        logic [10:0] px [6];
        logic [23:0] pc [6];
        px = '{11'd0, 11'd99, 11'd100, 11'd699, 11'd700, 11'd799};
        pc = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000, 24'h000000};
        mode = 2'd1;
        pulse_fs();
        fetch = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            for (int k = 0; k < 6; k++) begin
                if (px[k] == 11'(i)) begin
                    n_cmp++;
                    if (rgb !== pc[k] || x !== px[k]) begin
                        n_err++; $display("FAIL bars_x%0d: got rgb=%h x=%0d want %h", i, rgb, x, pc[k]);
                    end
                end
            end
        end
        tick();
        fetch = 1'b0;
        n_cmp++;
        if (rgb !== 24'hFFFFFF || x !== 11'd0 || y !== 11'd1) begin
            n_err++; $display("FAIL bars_newline: got rgb=%h x=%0d y=%0d want FFFFFF 0 1", rgb, x, y);
        end
    endtask

    task automatic test_rgb_cycle();
        logic [23:0] exp [4];
        exp = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};
        mode = 2'd2;
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) fetch_n(1);
            n_cmp++;
            if (rgb !== exp[i]) begin
                n_err++; $display("FAIL rgb_step%0d: got %h want %h", i, rgb, exp[i]);
            end
        end
        fetch_n(796);
        n_cmp++;
        if (rgb !== 24'h00FF00 || x !== 11'd799) begin
            n_err++; $display("FAIL rgb_x799: got rgb=%h x=%0d want 00FF00 799", rgb, x);
        end
        fetch_n(1);
        n_cmp++;
        if (rgb !== 24'hFF0000 || x !== 11'd0 || y !== 11'd1) begin
            n_err++; $display("FAIL rgb_newline: got rgb=%h x=%0d y=%0d want FF0000 0 1", rgb, x, y);
        end
    endtask

    task automatic test_checker();
        mode = 2'd3; solid = 24'hFFFFFF;
        pulse_fs();
        fetch_n(31);
        n_cmp++;
        if (rgb !== 24'hFFFFFF || x !== 11'd31) begin
            n_err++; $display("FAIL chk_31_0: got rgb=%h x=%0d want FFFFFF", rgb, x);
        end
        fetch_n(1);
        n_cmp++;
        if (rgb !== 24'h000000 || x !== 11'd32) begin
            n_err++; $display("FAIL chk_32_0: got rgb=%h x=%0d want 000000", rgb, x);
        end
        fetch_n(31 * 800);
        n_cmp++;
        if (rgb !== 24'h000000 || y !== 11'd31) begin
            n_err++; $display("FAIL chk_32_31: got rgb=%h y=%0d want 000000", rgb, y);
        end
        fetch_n(800);
        n_cmp++;
        if (rgb !== 24'hFFFFFF || x !== 11'd32 || y !== 11'd32) begin
            n_err++; $display("FAIL chk_32_32: got rgb=%h x=%0d y=%0d want FFFFFF", rgb, x, y);
        end
    endtask

    task automatic test_fs_collision();
        mode = 2'd0; solid = 24'hABCDEF;
        pulse_fs();
        fetch_n(5);
        n_cmp++;
        if (x !== 11'd5) begin
            n_err++; $display("FAIL coll_pre: got x=%0d want 5", x);
        end
        fs = 1'b1; fetch = 1'b1; tick(); fs = 1'b0; fetch = 1'b0;
        n_cmp++;
        if (x !== 11'd0 || y !== 11'd0 || fc !== 8'd0 || rgb !== 24'hABCDEF) begin
            n_err++; $display("FAIL coll_fs_wins: got x=%0d y=%0d fc=%0d rgb=%h want 0 0 0 ABCDEF", x, y, fc, rgb);
        end
        tick();
        n_cmp++;
        if (x !== 11'd0) begin
            n_err++; $display("FAIL coll_hold: got x=%0d want 0", x);
        end
    endtask

    task automatic test_frame_wrap();
        mode = 2'd0; solid = 24'hABCDEF;
        fs_s = 1'b1; tick(); fs_s = 1'b0;
        fetch_s_n(30);
        mode = 2'd2;
        fetch_s_n(33);
        n_cmp++;
        if (rgb_s !== 24'hABCDEF || x_s !== 11'd15 || y_s !== 11'd3 || fc_s !== 8'd0) begin
            n_err++; $display("FAIL wrap_pre: got rgb=%h x=%0d y=%0d fc=%0d want ABCDEF 15 3 0", rgb_s, x_s, y_s, fc_s);
        end
        fetch_s_n(1);
        n_cmp++;
        if (rgb_s !== 24'hFF0000 || x_s !== 11'd0 || y_s !== 11'd0 || fc_s !== 8'd1) begin
            n_err++; $display("FAIL wrap_eof: got rgb=%h x=%0d y=%0d fc=%0d want FF0000 0 0 1", rgb_s, x_s, y_s, fc_s);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        fetch_s_n(254 * 64);
        n_cmp++;
        if (fc_s !== 8'd255) begin
            n_err++; $display("FAIL fc_255: got %0d want 255", fc_s);
        end
        fetch_s_n(64);
        n_cmp++;
        if (fc_s !== 8'd0 || x_s !== 11'd0 || y_s !== 11'd0) begin
            n_err++; $display("FAIL fc_wrap: got fc=%0d x=%0d y=%0d want 0 0 0", fc_s, x_s, y_s);
        end
    endtask

`ifdef PATTERN_SCROLL_EN
    task automatic test_scroll();
        reset = 1'b1; tick(); reset = 1'b0;
        mode = 2'd1;
        fs_s = 1'b1; tick(); fs_s = 1'b0;
        fetch_s_n(128);
        // offset 2: x=0 -> column 2 (bar 1)
        n_cmp++;
        if (rgb_s !== 24'hFFFF00 || x_s !== 11'd0) begin
            n_err++; $display("FAIL scroll_x0: got rgb=%h x=%0d want FFFF00", rgb_s, x_s);
        end
        fetch_s_n(13);
        n_cmp++;
        if (rgb_s !== 24'h000000) begin
            n_err++; $display("FAIL scroll_x13: got %h want 000000", rgb_s);
        end
        fetch_s_n(1);
        n_cmp++;
        if (rgb_s !== 24'hFFFFFF) begin
            n_err++; $display("FAIL scroll_x14: got %h want FFFFFF", rgb_s);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bars();
        test_rgb_cycle();
        test_checker();
        test_fs_collision();
        test_frame_wrap();
        test_frame_cnt_wrap();
`ifdef PATTERN_SCROLL_EN
        test_scroll();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_pattern_gen.md
Name: pixel_pattern_gen

Overview:
- Pixel source that sits directly upstream of top_vgatest. It answers each fetch_next_pixel strobe with the next RGB888 pixel of a selectable test pattern.
- Tracks raster position (x, y) and a frame counter, so patterns are position-exact, not just sequence-based.
- Runs in the pixel clock domain. Its outputs drive top_vgatest r_i/g_i/b_i directly.

Parameters:
- X, 800, active pixels per line
- Y, 600, active lines per frame
- CELL_LOG2, 5, checkerboard cell size = 2**CELL_LOG2 pixels
- BAR_W, X/8, colour-bar width in pixels (integer division)

Ports:
- clk_pixel  in  1  pixel clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_next_pixel  in  1  one-cycle strobe: consumer has taken the current pixel, advance
- frame_start  in  1  one-cycle strobe: resynchronise to pixel (0,0)
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 RGB cycle, 3 checkerboard
- solid_rgb  in  24  {R,G,B} colour for mode 0 and for checkerboard "on" cells
- r_o  out  8  red of current pixel
- g_o  out  8  green of current pixel
- b_o  out  8  blue of current pixel
- x_o  out  11  current pixel column
- y_o  out  11  current pixel line
- frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async): x=0, y=0, frame_cnt=0, active mode=0, bar index=0, bar pixel counter=0, RGB-cycle state=R, r_o/g_o/b_o=0.
- r_o/g_o/b_o are registered. Every cycle they load f(next x, next y, active mode). Consequence:
  - The first edge after reset release shows pixel (0,0).
  - On the edge that accepts a fetch, the outputs already hold the new pixel. Latency from fetch to new pixel is 1 edge.
- Counter advance on fetch:
  - x<X-1: x+1.
  - x=X-1: x=0, then y+1.
  - x=X-1 and y=Y-1: y=0 and frame_cnt+1 (end of frame).
- mode is sampled into the active mode only at end of frame or on frame_start. No mode change mid-frame.
- frame_start:
  - Forces x=0, y=0, bar state=0, RGB state=R, and loads mode.
  - frame_cnt is unchanged.
  - If asserted in the same cycle as fetch_next_pixel, frame_start wins and the fetch is dropped.
- Colour bars (mode 1):
  - Bar index is derived from a per-line pixel counter (no divider). Index increments each BAR_W pixels and saturates at 7, so the last bar absorbs any remainder.
  - Index resets at x=0.
  - Order 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- RGB cycle (mode 2):
  - Each fetch steps R->G->B->R, giving FF0000, 00FF00, 0000FF.
  - The state returns to R at x=0 of every line.
- Checkerboard (mode 3): pixel is solid_rgb when x[CELL_LOG2] XOR y[CELL_LOG2] = 0, else 000000.
- Solid (mode 0): solid_rgb. The input is sampled continuously, not latched.
- Fetch with no frame_start ever: counters wrap naturally and free-run.
- Reset mid-line: immediate return to the reset state. No partial-frame recovery is needed.

Optional Feature:
- Macro PATTERN_SCROLL_EN.
- Defined:
  - Adds an 11-bit scroll offset, incremented by 1 at each end of frame and wrapping at X-1->0. Reset value 0.
  - Modes 1 and 3 use (x+offset) mod X in place of x.
  - Bar counters are preloaded from the offset at x=0.
- Undefined: no offset logic; patterns are static.

Test Plan:
- Reset, release, mode=0, solid_rgb=123456 -> first edge after release gives r_o=12, g_o=34, b_o=56, x_o=0, y_o=0.
- mode=1, frame_start, 800 fetches:
  - outputs FFFFFF for x=0..99, FFFF00 at x=100, 000000 at x=799;
  - after the 800th fetch, x_o=0, y_o=1, colour back to FFFFFF.
- mode=2, 4 fetches from x=0 -> FF0000, 00FF00, 0000FF, FF0000. Wrap to a new line -> state returns to FF0000.
- mode=3, solid_rgb=FFFFFF:
  - pixel (31,0)=FFFFFF and (32,0)=000000;
  - (32,32)=FFFFFF.
- 480000 fetches -> frame_cnt=1, x_o=0, y_o=0.
  - Changing mode mid-frame takes effect only after the wrap.
  - frame_start together with fetch at x=5 -> x_o=0, fetch ignored.
- PATTERN_SCROLL_EN, mode=1, two full frames -> on frame 2, pixel x=0 shows the colour of former x=2 (FFFFFF), and x=98 shows FFFF00.
